// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
//   Instruction-memory bus between the fetch stage and instruction memory.
//   Request channel is valid/ready; response channel is valid-only, with
//   exactly one response per accepted request, at least one cycle later.
//
//   imem_req_valid  fetch -> mem  request valid
//   imem_req_ready  mem -> fetch  memory accepts the request this cycle
//   imem_addr       fetch -> mem  request byte address, 4-byte aligned
//   imem_rsp_valid  mem -> fetch  response valid
//   imem_rsp_data   mem -> fetch  instruction word
//
//   modport master : fetch stage side
//   modport slave  : instruction memory side
// ---------------------------------------------------------------------------
interface fetch_stage_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage plus IF/ID pipeline register. Owns the PC, keeps
//   at most one instruction-memory request outstanding, and presents the
//   fetched word to decode. Decode back-pressure parks a returning word in a
//   one-entry hold buffer; a redirect from execute flushes IF/ID, the hold
//   buffer and any in-flight request.
//
//   Parameters
//     RESET_PC    PC loaded on reset
//     NOP_INSTR   word driven on instr_d while IF/ID holds nothing live
//
//   Ports
//     clk             clock, rising edge
//     rst             asynchronous active-high reset
//     imem            instruction-memory bus (fetch_stage_if.master)
//     stall_d         decode cannot accept; hold IF/ID
//     redirect_valid  taken branch/jump from execute
//     redirect_pc     redirect target, bits [1:0] ignored
//     valid_d         IF/ID holds a live instruction
//     instr_d         IF/ID instruction
//     pc_d            PC of instr_d
//     pc_plus4_d      pc_d + 4, link value for JAL/JALR
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_stage_if.master        imem,
    input  logic                 stall_d,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    output logic                 valid_d,
    output logic [31:0]          instr_d,
    output logic [31:0]          pc_d,
    output logic [31:0]          pc_plus4_d
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,   // issuing a request for pc
        ST_WAIT = 2'd1,   // one request outstanding
        ST_HOLD = 2'd2    // word parked in hold buffer, IF/ID was stalled
    } state_t;

    state_t      state;
    logic [31:0] pc;            // address of the next request
    logic [31:0] inflight_pc;   // address of the outstanding / held word
    logic        kill;          // outstanding response must be dropped
    logic        hold_valid;
    logic [31:0] hold_instr;

    logic        ifid_accept;
    logic        req_fire;
    logic [31:0] redirect_target;
    logic        unused_redirect_lsbs;

    // Request valid depends only on state, rst and redirect_valid, so there
    // is no combinational path from the response channel to the request.
    assign imem.imem_req_valid = !rst && (state == ST_REQ) && !redirect_valid;
    assign imem.imem_addr      = pc;

    assign req_fire        = imem.imem_req_valid && imem.imem_req_ready;
    assign ifid_accept     = !valid_d || !stall_d;
    assign redirect_target = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: every flop, including the hold buffer and inflight_pc,
            // is reset so that no X can ever propagate onto instr_d or pc_d.
            state       <= ST_REQ;
            pc          <= RESET_PC;
            inflight_pc <= RESET_PC;
            kill        <= 1'b0;
            hold_valid  <= 1'b0;
            hold_instr  <= NOP_INSTR;
            valid_d     <= 1'b0;
            instr_d     <= NOP_INSTR;
            pc_d        <= 32'h0000_0000;
            pc_plus4_d  <= 32'h0000_0004;
        end else begin
            // Decode consumed the current instruction; empty IF/ID unless a
            // new word is loaded below.
            // NOTE: all state uses non-blocking assignments, so a later
            // assignment in this block cleanly overrides this default.
            if (valid_d && !stall_d) begin
                valid_d <= 1'b0;
                instr_d <= NOP_INSTR;
            end

            if (redirect_valid) begin
                // Redirect wins over everything, including decode stall.
                pc         <= redirect_target;
                valid_d    <= 1'b0;
                instr_d    <= NOP_INSTR;
                hold_valid <= 1'b0;
                case (state)
                    ST_WAIT: begin
                        if (imem.imem_rsp_valid) begin
                            // Response for the flushed request lands now.
                            kill  <= 1'b0;
                            state <= ST_REQ;
                        end else begin
                            kill  <= 1'b1;
                        end
                    end
                    ST_HOLD: state <= ST_REQ;
                    default: state <= ST_REQ;
                endcase
            end else begin
                case (state)
                    ST_REQ: begin
                        if (req_fire) begin
                            inflight_pc <= pc;
                            pc          <= pc + 32'd4;
                            state       <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (imem.imem_rsp_valid) begin
                            if (kill) begin
                                kill  <= 1'b0;
                                state <= ST_REQ;
                            end else if (ifid_accept) begin
                                valid_d    <= 1'b1;
                                instr_d    <= imem.imem_rsp_data;
                                pc_d       <= inflight_pc;
                                pc_plus4_d <= inflight_pc + 32'd4;
                                state      <= ST_REQ;
                            end else begin
                                hold_valid <= 1'b1;
                                hold_instr <= imem.imem_rsp_data;
                                state      <= ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (ifid_accept) begin
                            valid_d    <= 1'b1;
                            instr_d    <= hold_instr;
                            pc_d       <= inflight_pc;
                            pc_plus4_d <= inflight_pc + 32'd4;
                            hold_valid <= 1'b0;
                            state      <= ST_REQ;
                        end
                    end
                    default: state <= ST_REQ;
                endcase
            end
        end
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register.
- Owns the PC and issues one instruction-memory request at a time over a valid/ready request channel and a valid-only response channel.
- Presents the fetched word to decode; decode slices Op = instr_d[6:0], funct3 = instr_d[14:12] and funct7 = instr_d[31:25] for the control unit.
- Handles decode back-pressure (stall), and branch/jump redirects with flush of in-flight and buffered instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, value driven on instr_d while the register holds no valid instruction (addi x0,x0,0).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req_valid  output  1  request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_addr  output  32  request byte address; always 4-byte aligned.
- imem_rsp_valid  input  1  response valid; exactly one response per accepted request, at least 1 cycle later.
- imem_rsp_data  input  32  instruction word.
- stall_d  input  1  decode cannot accept; hold IF/ID.
- redirect_valid  input  1  taken branch/jump from execute.
- redirect_pc  input  32  redirect target; bits [1:0] ignored (treated as 0).
- valid_d  output  1  IF/ID holds a live instruction.
- instr_d  output  32  IF/ID instruction.
- pc_d  output  32  PC of instr_d.
- pc_plus4_d  output  32  pc_d + 4, for JAL/JALR link writeback.

Behaviour:
- Reset (async): state=REQ, pc=RESET_PC, kill=0, hold_valid=0, valid_d=0, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=4.
  - While rst is high: imem_req_valid=0.
- Address arithmetic: all PC arithmetic is mod 2^32. 32'hFFFF_FFFC + 4 wraps to 0.
- States:
  - REQ: imem_req_valid = !redirect_valid; imem_addr = pc.
    - On handshake (valid && ready): inflight_pc <= pc, pc <= pc+4, go WAIT.
  - WAIT: imem_req_valid=0. Waits for imem_rsp_valid.
    - On response with kill=1: discard the word, clear kill, go REQ.
    - On response with kill=0 and the IF/ID register accepting: load IF/ID (instr_d=data, pc_d=inflight_pc, pc_plus4_d=inflight_pc+4, valid_d=1), go REQ.
    - On response with kill=0 and IF/ID not accepting: capture the word into the hold buffer (hold_valid=1), go HOLD.
  - HOLD: imem_req_valid=0. When IF/ID accepts: move hold buffer into IF/ID, hold_valid=0, go REQ.
- IF/ID accepts when (!valid_d || !stall_d).
  - If valid_d && !stall_d and no new word is loaded that cycle: valid_d<=0, instr_d<=NOP_INSTR.
  - While valid_d && stall_d: instr_d, pc_d and pc_plus4_d are held stable.
- Redirect (highest priority, any state):
  - pc <= {redirect_pc[31:2],2'b00}.
  - valid_d <= 0 and instr_d <= NOP_INSTR, regardless of stall_d.
  - hold_valid <= 0.
  - REQ: no request issued that cycle; stay in REQ.
  - WAIT with no response this cycle: kill <= 1, stay in WAIT.
  - WAIT with response this cycle: word discarded, go REQ.
  - HOLD: go REQ.
- Throughput: at most one outstanding request. Best case is one instruction per 2 cycles (request, response).
- No combinational path from imem_rsp_* to imem_req_*. imem_req_valid depends combinationally only on state, rst and redirect_valid.

Test Plan:
- Reset then free-running memory (ready=1, response 1 cycle after accept, data = addr ^ 32'hA5A5_0000), stall_d=0:
  - requests at 0x0, 0x4, 0x8;
  - valid_d pulses with pc_d=0x0 / instr_d=32'hA5A5_0000, then pc_d=0x4, pc_d=0x8;
  - pc_plus4_d = pc_d + 4.
- stall_d held high for 5 cycles while IF/ID holds pc 0x4:
  - instr_d and pc_d stay stable;
  - the response for 0x8 is captured into the hold buffer and state=HOLD;
  - no new request is issued;
  - after release, 0x8 appears the next cycle and fetch resumes at 0xC.
- Redirect to 0x100 during WAIT for 0x10, with the response arriving 3 cycles later:
  - valid_d drops immediately;
  - the 0x10 word never reaches IF/ID;
  - the next request address is 0x100.
- Redirect to 0x203 asserted in the same cycle as the response for 0x20:
  - the 0x20 word is discarded;
  - the next request is 0x200;
  - valid_d=0 throughout.
- Redirect while in HOLD with stall_d=1:
  - valid_d=0 next cycle despite the stall;
  - the hold buffer is dropped;
  - fetch resumes at the redirect target.
- rst asserted mid-WAIT (asynchronous, between clock edges):
  - outputs return to reset values immediately;
  - after release, the first request is RESET_PC;
  - the stale response returned while rst is high is ignored.
